binom_seq: RTL and testbench

- Sequencer that computes the binomial coefficient C(n,k) by issuing one operation per cycle to the external 32-bit combinational ALU.
- It is the initiator end of the ALU interface: it drives opcode and operands, then consumes the result and zero flag.
- It sits between the top-level start/done control and the shared ALU.

---
 rtl/binom_seq.sv | 202 ++++++++++++++++++++
 tb/tb_binom_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/binom_seq.sv
// binom_seq: computes C(n,k) by issuing one operation per cycle to a shared combinational ALU.
// Latency: done rises 3+5k edges after start (1 edge when k>n); 4+5*min(k,n-k) with BINOM_SYM_EN.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
//
// Optional feature macro: BINOM_SYM_EN -- adds a SYM state after SUBT that swaps
// k and n-k so the loop runs min(k,n-k) times. Results are identical in both builds.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   start, n, k           request pulse and operands, captured in IDLE
//   busy, done, err       status: busy while computing, one-cycle done, err when k>n
//   result                C(n,k), holds until overwritten by a later computation
//   alu_sel/e1/e2         ALU opcode and operands, combinational from state
//   alu_res, alu_zf       ALU result and zero flag, captured at the end of the cycle
module binom_seq #(
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic [NW-1:0] k,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   result,
  output logic [3:0]    alu_sel,
  output logic [31:0]   alu_e1,
  output logic [31:0]   alu_e2,
  input  logic [31:0]   alu_res,
  input  logic          alu_zf
);

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_DIV  = 4'b0111;
  localparam logic [3:0] OP_LT   = 4'b1000;
  localparam logic [3:0] OP_EQ   = 4'b1001;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CHK  = 4'd1,
    S_SUBT = 4'd2,
    S_SYM  = 4'd3,
    S_EQ   = 4'd4,
    S_INCI = 4'd5,
    S_INCT = 4'd6,
    S_MUL  = 4'd7,
    S_DIV  = 4'd8,
    S_DONE = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] c_q, c_d;
  logic [31:0] i_q, i_d;
  logic [31:0] t_q, t_d;
  logic [31:0] kk_q, kk_d;
  logic [31:0] nn_q, nn_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      c_q      <= 32'd0;
      i_q      <= 32'd0;
      t_q      <= 32'd0;
      kk_q     <= 32'd0;
      nn_q     <= 32'd0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      i_q      <= i_d;
      t_q      <= t_d;
      kk_q     <= kk_d;
      nn_q     <= nn_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    i_d      = i_q;
    t_d      = t_q;
    kk_d     = kk_q;
    nn_d     = nn_q;
    result_d = result_q;
    err_d    = err_q;
    alu_sel  = OP_NONE;
    alu_e1   = 32'd0;
    alu_e2   = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nn_d    = 32'(n);
          kk_d    = 32'(k);
          c_d     = 32'd1;
          i_d     = 32'd0;
          err_d   = 1'b0;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        // Less-than yields 1 (zf=0) when n<k: invalid request.
        alu_sel = OP_LT;
        alu_e1  = nn_q;
        alu_e2  = kk_q;
        if (!alu_zf) begin
          result_d = 32'd0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_SUBT;
        end
      end
      S_SUBT: begin
        alu_sel = OP_SUB;
        alu_e1  = nn_q;
        alu_e2  = kk_q;
        t_d     = alu_res;
`ifdef BINOM_SYM_EN
        state_d = S_SYM;
`else
        state_d = S_EQ;
`endif
      end
`ifdef BINOM_SYM_EN
      S_SYM: begin
        // When n-k < k, iterate over n-k instead: C(n,k) == C(n,n-k).
        alu_sel = OP_LT;
        alu_e1  = t_q;
        alu_e2  = kk_q;
        if (!alu_zf) begin
          kk_d = t_q;
          t_d  = kk_q;
        end
        state_d = S_EQ;
      end
`endif
      S_EQ: begin
        // Equality yields 1 (zf=0) once i has reached k.
        alu_sel = OP_EQ;
        alu_e1  = i_q;
        alu_e2  = kk_q;
        if (!alu_zf) begin
          result_d = c_q;
          state_d  = S_DONE;
        end else begin
          state_d = S_INCI;
        end
      end
      S_INCI: begin
        alu_sel = OP_ADD;
        alu_e1  = i_q;
        alu_e2  = 32'd1;
        i_d     = alu_res;
        state_d = S_INCT;
      end
      S_INCT: begin
        alu_sel = OP_ADD;
        alu_e1  = t_q;
        alu_e2  = 32'd1;
        t_d     = alu_res;
        state_d = S_MUL;
      end
      S_MUL: begin
        alu_sel = OP_MUL;
        alu_e1  = c_q;
        alu_e2  = t_q;
        c_d     = alu_res;
        state_d = S_DIV;
      end
      S_DIV: begin
        // Exact: c*(n-k+i) is always divisible by i, leaving C(n-k+i, i).
        alu_sel = OP_DIV;
        alu_e1  = c_q;
        alu_e2  = i_q;
        c_d     = alu_res;
        state_d = S_EQ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_binom_seq.sv
module tb_binom_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  n, k;
  logic        busy, done, err;
  logic [31:0] result;
  logic [3:0]  alu_sel;
  logic [31:0] alu_e1, alu_e2, alu_res;
  logic        alu_zf;

  binom_seq #(.NW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .k(k),
    .busy(busy), .done(done), .err(err), .result(result),
    .alu_sel(alu_sel), .alu_e1(alu_e1), .alu_e2(alu_e2),
    .alu_res(alu_res), .alu_zf(alu_zf)
  );

  always #5 clk = ~clk;

  // External 32-bit combinational ALU.
  always_comb begin
    alu_res = 32'd0;
    case (alu_sel)
      4'b0100: alu_res = alu_e1 + alu_e2;
      4'b0101: alu_res = alu_e1 - alu_e2;
      4'b0110: alu_res = alu_e1 * alu_e2;
      4'b0111: alu_res = (alu_e2 == 32'd0) ? 32'd0 : alu_e1 / alu_e2;
      4'b1000: alu_res = (alu_e1 < alu_e2) ? 32'd1 : 32'd0;
      4'b1001: alu_res = (alu_e1 == alu_e2) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
  end
  assign alu_zf = (alu_res == 32'd0);

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          st;
  } exp_t;

  exp_t   exp_q[$];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  longint pas[31][31];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference model: Pascal's triangle plus latency rules stated in cycles.
  function automatic exp_t model(input int nv, input int kv, input int st);
    exp_t e;
    int   m;
    e.st = st;
    if (kv > nv) begin
      e.res = 32'd0;
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      e.res = 32'(pas[nv][kv]);
      e.err = 1'b0;
      m = (kv < nv - kv) ? kv : nv - kv;
`ifdef BINOM_SYM_EN
      e.lat = 4 + 5 * m;
`else
      e.lat = 3 + 5 * kv + 0 * m;
`endif
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("err", 32'(err), 32'(e.err));
        chk("latency", 32'(cyc - e.st), 32'(e.lat));
      end
    end
  end

  // Issue one request; optionally pulse a stray start glitch_at cycles in.
  task automatic do_txn(input int nv, input int kv, input int glitch_at);
    exp_t e;
    bit   ok;
    @(negedge clk);
    start = 1'b1;
    n = 8'(nv);
    k = 8'(kv);
    e = model(nv, kv, cyc + 1);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (glitch_at > 0 && c == glitch_at) begin
        start = 1'b1;
        n = 8'd2;
        k = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!ok) begin
      chk("timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    chk("result_hold", result, e.res);
    chk("done_low", 32'(done), 32'd0);
    chk("busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    bit hit;
    int nv, kv;
    for (int a = 0; a < 31; a++) begin
      for (int b = 0; b < 31; b++) begin
        if (b == 0 || b == a) pas[a][b] = 1;
        else if (b > a) pas[a][b] = 0;
        else pas[a][b] = pas[a-1][b-1] + pas[a-1][b];
      end
    end

    rst = 1'b1;
    start = 1'b0;
    n = 8'd0;
    k = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_alu_e1", alu_e1, 32'd0);
    chk("rst_alu_e2", alu_e2, 32'd0);
    rst = 1'b0;

    do_txn(5, 2, 0);
    do_txn(3, 5, 0);
    do_txn(4, 4, 0);
    do_txn(30, 15, 0);
    do_txn(7, 0, 0);
    do_txn(5, 4, 0);
    do_txn(0, 0, 0);
    do_txn(6, 3, 4);

    // Abort in MUL, then restart.
    @(negedge clk);
    start = 1'b1;
    n = 8'd10;
    k = 8'd5;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (alu_sel == 4'b0110) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_mul", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_alu_sel", 32'(alu_sel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_txn(10, 5, 0);

    for (int r = 0; r < 20; r++) begin
      nv = $urandom_range(0, 30);
      if ($urandom_range(0, 7) == 0) kv = nv + $urandom_range(1, 3);
      else kv = $urandom_range(0, nv);
      do_txn(nv, kv, 0);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
